// File: rtl/risc_v_data_memory.sv
// RV32I data memory with fixed-latency valid/ready request and response.
// Byte/half/word loads and stores with sign handling and fault detection.
module risc_v_data_memory #(
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);

  localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]            r_cnt;
  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_error;
  logic [31:0]           r_mem [MEM_WORDS];

  logic            w_accept;
  logic            w_commit;
  logic            w_bad_f3;
  logic            w_is_b;
  logic            w_is_h;
  logic            w_is_w;
  logic            w_uns;
  logic            w_misal;
  logic            w_oor;
  logic            w_err;
  logic [IW-1:0]   w_midx;
  logic [31:0]     w_word;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ldata;
  logic [3:0]      w_be;
  logic [31:0]     w_wd;

  assign w_accept = req_valid & req_ready;
  assign w_commit = (r_state == WAIT) && (r_cnt == 4'd0);

  // State register and latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= 4'(LATENCY - 1);
      else if (r_state == WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_next = WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE);
    rsp_valid = (r_state == RESP);
    rsp_rdata = r_rdata;
    rsp_error = r_error;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
  end

  assign w_bad_f3 = (r_funct3 == 3'b011) || (r_funct3 == 3'b110) ||
                    (r_funct3 == 3'b111);
  assign w_is_b   = !w_bad_f3 && (r_funct3[1:0] == 2'b00);
  assign w_is_h   = !w_bad_f3 && (r_funct3[1:0] == 2'b01);
  assign w_is_w   = !w_bad_f3 && (r_funct3[1:0] == 2'b10);
  assign w_uns    = r_funct3[2];
  assign w_misal  = (w_is_h && r_addr[0]) ||
                    (w_is_w && (r_addr[1:0] != 2'b00));
  assign w_oor    = 32'(r_addr[ADDR_WIDTH-1:2]) >= 32'(MEM_WORDS);
  assign w_err    = w_bad_f3 || w_misal || w_oor;

  assign w_midx = IW'(r_addr[ADDR_WIDTH-1:2]);
  assign w_word = r_mem[w_midx];
  assign w_byte = w_word[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_ldata = 32'd0;
    if (!r_write && !w_err) begin
      unique case (1'b1)
        w_is_b:  w_ldata = w_uns ? {24'd0, w_byte}
                                 : {{24{w_byte[7]}}, w_byte};
        w_is_h:  w_ldata = w_uns ? {16'd0, w_half}
                                 : {{16{w_half[15]}}, w_half};
        w_is_w:  w_ldata = w_word;
        default: w_ldata = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_be = 4'b0000;
    w_wd = r_wdata;
    unique case (1'b1)
      w_is_b: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {4{r_wdata[7:0]}};
      end
      w_is_h: begin
        w_be = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{r_wdata[15:0]}};
      end
      w_is_w:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  // Load data and fault flag are frozen on the commit edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'd0;
      r_error <= 1'b0;
    end else if (w_commit) begin
      r_rdata <= w_ldata;
      r_error <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && r_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i])
          r_mem[w_midx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

endmodule
